// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_responder
// Purpose  : Memory-side responder for the data cache line interface. Takes
//            one line request at a time and completes it as Beats sequential
//            word-wide beats on the memory port: fills gather the returned
//            beats into a line, writebacks serialize the dirty line.
// Ports    : clk, reset_n        - clock, asynchronous active-low reset
//            drequest/dreqack    - cache request handshake (ack is a pulse)
//            dwrenable, daddr,   - request type, line address, writeback line
//            dwdata
//            drdata, ddone       - fill line and completion pulse
//            mem_req/mem_ready   - beat request handshake
//            mem_we, mem_addr,   - beat direction, byte address, write data
//            mem_wdata
//            mem_rvalid,         - in-order read beat returns
//            mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_responder #(
    parameter int LineBits = 512,
    parameter int BeatBits = 64,
    parameter int Beats    = LineBits / BeatBits
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                drequest,
    input  logic                dwrenable,
    input  logic [63:0]         daddr,
    input  logic [LineBits-1:0] dwdata,
    output logic                dreqack,
    output logic [LineBits-1:0] drdata,
    output logic                ddone,
    output logic                mem_req,
    output logic                mem_we,
    output logic [63:0]         mem_addr,
    output logic [BeatBits-1:0] mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [BeatBits-1:0] mem_rdata
);

    localparam int                 c_cnt_w      = $clog2(Beats + 1);
    localparam logic [c_cnt_w-1:0] c_beats      = c_cnt_w'(Beats);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [63:0]        c_beat_bytes = 64'(BeatBits / 8);
    // Clears the byte offset within a line.
    localparam logic [63:0]        c_line_mask  = ~(64'(LineBits / 8) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [63:0]           base_q,    base_d;
    logic                  we_q,      we_d;
    logic [LineBits-1:0]   line_q,    line_d;
    logic [LineBits-1:0]   drdata_q,  drdata_d;
    logic [c_cnt_w-1:0]    iss_cnt_q, iss_cnt_d;
    logic [c_cnt_w-1:0]    ret_cnt_q, ret_cnt_d;
    logic                  dreqack_q, dreqack_d;

    logic                  w_beat_fire;
    logic                  w_ret_fire;

    // ------------------------------------------------------------------
    // Outputs: derived from registered state so that an asynchronous
    // reset forces them to their idle values immediately.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = (state_q == XFER) && (iss_cnt_q < c_beats);
        mem_we    = (state_q == XFER) && we_q;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == XFER) begin
            mem_addr = base_q + 64'(iss_cnt_q) * c_beat_bytes;
        end
        if (mem_req) begin
            for (int b = 0; b < Beats; b++) begin
                if (iss_cnt_q == c_cnt_w'(b)) begin
                    mem_wdata = line_q[b*BeatBits +: BeatBits];
                end
            end
        end
    end

    assign ddone   = (state_q == DONE);
    assign dreqack = dreqack_q;
    assign drdata  = drdata_q;

    // Returns are only meaningful during a fill and until the line is full;
    // anything else on mem_rvalid is dropped.
    assign w_beat_fire = mem_req && mem_ready;
    assign w_ret_fire  = (state_q == XFER) && !we_q && mem_rvalid &&
                         (ret_cnt_q < c_beats);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        we_d      = we_q;
        line_d    = line_q;
        drdata_d  = drdata_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        dreqack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (drequest) begin
                    base_d    = daddr & c_line_mask;
                    we_d      = dwrenable;
                    line_d    = dwrenable ? dwdata : '0;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    dreqack_d = 1'b1;
                    state_d   = XFER;
                end
            end

            XFER: begin
                if (w_beat_fire) begin
                    iss_cnt_d = iss_cnt_q + c_cnt_one;
                end
                if (w_ret_fire) begin
                    for (int b = 0; b < Beats; b++) begin
                        if (ret_cnt_q == c_cnt_w'(b)) begin
                            line_d[b*BeatBits +: BeatBits] = mem_rdata;
                        end
                    end
                    ret_cnt_d = ret_cnt_q + c_cnt_one;
                end
                // Exit on the updated counts so the last beat's own cycle
                // finishes the transfer. Writes are posted, so the last
                // issue completes them.
                if (we_q && (iss_cnt_d == c_beats)) begin
                    state_d = DONE;
                end else if (!we_q && (ret_cnt_d == c_beats)) begin
                    drdata_d = line_d;
                    state_d  = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            we_q      <= 1'b0;
            line_q    <= '0;
            drdata_q  <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            dreqack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            we_q      <= we_d;
            line_q    <= line_d;
            drdata_q  <= drdata_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            dreqack_q <= dreqack_d;
        end
    end

endmodule
`default_nettype wire
